uart_tx: RTL and testbench
==========================

# uart_tx

Transmit-only UART serializer. It converts a parallel byte into an 8N1 asynchronous serial frame (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity), using a fixed integer clock-per-bit divider. It is the host-side byte transmitter for the command link into `nes_fpga_top_lvl`, and the same block serves as the FPGA's return-path transmitter. It runs in the 25 MHz domain produced by `clkdiv2`.

## Interface
- One clock; reset is synchronous and active-high.
- `CLKS_PER_BIT`, default 217 (25 MHz / 115200 baud): clock cycles per serial bit. Legal range is 2 or more. The command bench uses 5.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_start`  in  1: request to send `tx_data`. It is sampled every cycle and is honoured only in IDLE.
- `tx_data`  in  8: byte to send. It is captured on the accepting edge.
- `tx_active`  out  1: high while a frame is in flight.
- `tx_serial`  out  1: serial line. It idles high.
- `tx_done`  out  1: one-cycle pulse marking frame completion.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx_serial`=1 and `tx_active`=0.
  - When `tx_start`=1: latch `tx_data` into a shift register, clear the bit counter and the index, set `tx_active`=1, and go to START.
- START:
  - Drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with index 0.
- DATA:
  - Drive `shift[index]` for `CLKS_PER_BIT` cycles per bit, bits 0 through 7 (LSB first).
  - After bit 7, go to STOP.
- STOP:
  - Drive 1 for `CLKS_PER_BIT` cycles.
  - On the last cycle's edge: go to IDLE, set `tx_active`=0, set `tx_done`=1.
- `tx_done` is high for exactly one cycle. It is cleared on the next edge.
- Arithmetic:
  - Bit counter width is $clog2(`CLKS_PER_BIT`). It counts 0 to `CLKS_PER_BIT`-1 and wraps on bit boundaries.
  - Bit index is 3 bits.
- Changes to `tx_data` after acceptance have no effect on the current frame.
- `tx_start` while busy (START, DATA or STOP) is ignored; it is neither queued nor an error.
- `tx_start` held high continuously sends back-to-back frames. Each new frame starts on the cycle after `tx_done`.
- Reset, including mid-frame, takes effect at the next edge:
  - State = IDLE.
  - `tx_serial`=1, `tx_active`=0, `tx_done`=0.
  - Counters cleared. The partial frame is abandoned.

## Timing
- Let E0 be the edge at which `tx_start` is accepted in IDLE.
- From E0: `tx_serial` falls to 0 and `tx_active` rises to 1. All outputs are registered, so there is no combinational path from any input to any output.
- Data bit k is driven from E0 + (k+1)·`CLKS_PER_BIT`.
- Stop bit is driven from E0 + 9·`CLKS_PER_BIT`.
- At E0 + 10·`CLKS_PER_BIT`:
  - `tx_active` falls to 0 and `tx_done` rises to 1.
  - `tx_serial` stays 1.
- Total frame length is exactly 10·`CLKS_PER_BIT` cycles.
- Earliest next acceptance is the edge at E0 + 10·`CLKS_PER_BIT` + 1 (`tx_start` sampled while in IDLE).
- Handshake: the user asserts `tx_start` for at least one cycle while `tx_active`=0. Waiting for `tx_active`=0 is sufficient before the next request.

## Structure
- Shared package `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t`. The companion `uart_rx` uses the same package.
  - The default-baud constant `UART_CLKS_PER_BIT_DEFAULT` = 217.
- Single flat module with no sub-modules.
- Registers: state, bit counter, bit index, shift register, and the three output flops.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `tx_start`=1.
  - Required: `tx_serial`=1, `tx_active`=0, `tx_done`=0 throughout.
  - Required: no frame starts until after `rst`=0.
- Single byte 0xA5 with `CLKS_PER_BIT`=5:
  - Required line sequence, each level held 5 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - Required: `tx_done` pulses once, at cycle 50 after acceptance.
- Busy rejection: send 0x02, then pulse `tx_start` with 0xFF at cycles 3 and 27 of the frame.
  - Required: only 0x02 is transmitted; it decodes as 0x02 in the `uart_rx` loopback.
  - Required: exactly one `tx_done`.
- Back-to-back: hold `tx_start`=1 with data 0x80 then 0x01.
  - Required: two frames separated by exactly one idle-high cycle.
  - Required: `tx_done` pulses at 50 and 101.
- Mid-frame reset: assert `rst` at cycle 23 of a frame, release, then send 0x3C.
  - Required: the line returns to 1 on the next edge.
  - Required: 0x3C then transmits cleanly; the loopback receiver gets 0x3C.
- Loopback of all 256 byte values through `uart_rx` at `CLKS_PER_BIT`=5: every received byte equals the byte sent.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   uart_tx_state_t             - frame sequencing states (IDLE, START, DATA, STOP)
//   UART_CLKS_PER_BIT_DEFAULT   - clocks per bit for 25 MHz / 115200 baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 217;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// uart_tx: transmit-only 8N1 UART serializer with a fixed clocks-per-bit divider.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tx_start   in   request to send tx_data; honoured only while idle
//   tx_data    in   byte to send, captured on the accepting edge
//   tx_active  out  high while a frame is in flight
//   tx_serial  out  serial line, idles high
//   tx_done    out  one-cycle pulse on the edge that ends the stop bit
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: tx_start is a level sampled every cycle; a request is accepted
// on any rising edge where the block is idle and tx_start=1. Requests made
// while a frame is in flight are dropped, not queued. Waiting for
// tx_active=0 before raising tx_start is sufficient.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tx_start,
    input  logic [7:0]     tx_data,
    output logic           tx_active,
    output logic           tx_serial,
    output logic           tx_done,
    output uart_tx_state_t dbg_state
);

    // Counter must still be at least one bit wide when CLKS_PER_BIT is 2
    // (or an out-of-range 1).
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic             bit_last;
    logic [2:0]       idx_inc;

    assign bit_last = (cnt_q == CNT_LAST);
    assign idx_inc  = idx_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (tx_start) begin
                    shift_d  = tx_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b0;   // start bit appears on the accepting edge
                    active_d = 1'b1;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_last) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        // The next bit is presented on the same edge that
                        // advances the index, so look one position ahead.
                        idx_d    = idx_inc;
                        serial_d = shift_q[idx_inc];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_last) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign tx_active = active_q;
    assign tx_serial = serial_q;
    assign tx_done   = done_q;
    assign dbg_state = state_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT=5.
// A frame-level model predicts the line from the accept time and the byte;
// a line decoder recovers bytes from tx_serial and checks them against the
// bytes the model saw accepted.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB   = 5;
    localparam int FRAME = 10 * CPB;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tx_start = 1'b1;
    logic [7:0]     tx_data = 8'h55;
    logic           tx_active;
    logic           tx_serial;
    logic           tx_done;
    uart_tx_state_t dbg_state;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_serial (tx_serial),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- frame-level model ----------------
    // Knows only: accept time e0, captured byte, and that the line shows
    // start/d0..d7/stop for CPB cycles each, with done at e0+FRAME.
    int         cyc = 0;
    bit         m_busy = 1'b0;
    int         m_e0 = 0;
    logic [7:0] m_byte = '0;
    logic       exp_serial = 1'b1;
    logic       exp_active = 1'b0;
    logic       exp_done = 1'b0;
    bit         model_valid = 1'b0;
    bit         rx_kill = 1'b0;

    always @(posedge clk) begin
        int t;
        cyc++;
        exp_done = 1'b0;
        if (rst) begin
            // An abandoned frame never reaches the decoder's stop sample.
            if (m_busy && (cyc - m_e0) < 9 * CPB && exp_q.size() > 0)
                exp_q.delete(exp_q.size() - 1);
            m_busy      = 1'b0;
            rx_kill     = 1'b1;
            model_valid = 1'b1;
        end else begin
            if (m_busy && (cyc - m_e0) == FRAME) begin
                m_busy   = 1'b0;
                exp_done = 1'b1;
            end else if (!m_busy && tx_start) begin
                m_busy = 1'b1;
                m_e0   = cyc;
                m_byte = tx_data;
                exp_q.push_back(tx_data);
            end
        end
        exp_serial = 1'b1;
        exp_active = 1'b0;
        if (m_busy) begin
            t = cyc - m_e0;
            exp_active = 1'b1;
            if (t < CPB)            exp_serial = 1'b0;
            else if (t < 9 * CPB)   exp_serial = m_byte[t / CPB - 1];
            else                    exp_serial = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            check("tx_serial", tx_serial, exp_serial);
            check("tx_active", tx_active, exp_active);
            check("tx_done",   tx_done,   exp_done);
        end
    end

    // ---------------- line decoder (loopback) ----------------
    bit         rx_busy = 1'b0;
    int         rx_k = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        int j;
        if (rx_kill) begin
            rx_busy = 1'b0;
            rx_kill = 1'b0;
        end else if (model_valid) begin
            if (!rx_busy) begin
                if (tx_serial === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_k    = 0;
                end
            end else begin
                rx_k++;
                if (rx_k == CPB / 2) begin
                    check("rx_start_bit", tx_serial, 1'b0);
                end else if (rx_k > CPB / 2 && ((rx_k - CPB / 2) % CPB) == 0) begin
                    j = (rx_k - CPB / 2) / CPB;
                    if (j <= 8) begin
                        rx_byte[j - 1] = tx_serial;
                    end else begin
                        check("rx_stop_bit", tx_serial, 1'b1);
                        rx_busy = 1'b0;
                        if (exp_q.size() == 0) fail_now("rx_unexpected_byte");
                        else check("rx_byte", rx_byte, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (tx_active === 1'b0) return;
            tick();
        end
        fail_now("idle_timeout");
    endtask

    // Raise tx_start for one cycle; returns at the sample just after the
    // accepting edge (offset k=0).
    task automatic start_frame(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        logic [9:0] fbits;
        int         n_done;

        // Reset held 3 cycles with tx_start high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_serial", tx_serial, 1'b1);
            check("rst_active", tx_active, 1'b0);
            check("rst_done",   tx_done,   1'b0);
        end
        rst      = 1'b0;
        tx_start = 1'b0;
        tick();
        check("post_rst_active", tx_active, 1'b0);

        // Single byte 0xA5: literal line sequence, done at offset 50.
        wait_idle();
        start_frame(8'hA5);
        fbits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k <= FRAME; k++) begin
            if (k < FRAME) check("a5_line", tx_serial, fbits[k / CPB]);
            else           check("a5_line_end", tx_serial, 1'b1);
            check("a5_done", tx_done, (k == FRAME) ? 1'b1 : 1'b0);
            if (k == 0) check("a5_active_rise", tx_active, 1'b1);
            if (k == FRAME) check("a5_active_fall", tx_active, 1'b0);
            tick();
        end

        // Busy rejection: 0x02, with 0xFF requests at offsets 3 and 27.
        wait_idle();
        start_frame(8'h02);
        n_done = 0;
        for (int k = 0; k < 56; k++) begin
            if (tx_done === 1'b1) n_done++;
            if (k == 3 || k == 27) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            tick();
        end
        tx_start = 1'b0;
        check("busy_done_count", n_done, 1);

        // Back-to-back: tx_start held, 0x80 then 0x01.
        wait_idle();
        tx_data  = 8'h80;
        tx_start = 1'b1;
        tick();
        tx_data = 8'h01;
        for (int k = 0; k <= 2 * FRAME + 1; k++) begin
            check("b2b_done", tx_done, (k == FRAME || k == 2 * FRAME + 1) ? 1'b1 : 1'b0);
            if (k == FRAME)     check("b2b_gap_high", tx_serial, 1'b1);
            if (k == FRAME + 1) check("b2b_second_start", tx_serial, 1'b0);
            if (k == FRAME + 1) tx_start = 1'b0;
            tick();
        end

        // Mid-frame reset at offset 23, then a clean 0x3C.
        wait_idle();
        start_frame(8'h99);
        for (int k = 0; k < 22; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst_serial", tx_serial, 1'b1);
        check("midrst_active", tx_active, 1'b0);
        check("midrst_done",   tx_done,   1'b0);
        rst = 1'b0;
        tick();
        start_frame(8'h3C);
        wait_idle();
        repeat (3) tick();
        check("midrst_3c_drained", exp_q.size(), 0);

        // All 256 values with random gaps, random hold length, data churn
        // after acceptance and stray requests while busy.
        for (int b = 0; b < 256; b++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
            tx_data  = 8'(b);
            tx_start = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                tick();
                tx_data = 8'($urandom);
            end
            tx_start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) tick();
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
                tick();
                tx_start = 1'b0;
            end
        end

        wait_idle();
        repeat (FRAME + 5) tick();
        check("all_bytes_received", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx
